// File: rtl/data_checker.sv
// data_checker: receive-side pattern and framing checker for 512-bit generated
// test packets. It compares each accepted beat against the expected pattern and
// checks TLAST against the latched packet length. It also keeps packet, cycle and
// saturating error statistics, plus a capture of the first error.
module data_checker #(
    parameter int ERR_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [7:0]           packet_length,
    input  logic                 clear,
    input  logic                 rx_pause,
    input  logic [511:0]         AXIS_RX_TDATA,
    input  logic [63:0]          AXIS_RX_TKEEP,
    input  logic                 AXIS_RX_TVALID,
    input  logic                 AXIS_RX_TLAST,
    output logic                 AXIS_RX_TREADY,
    output logic [63:0]          packets_received,
    output logic [63:0]          cycles_received,
    output logic [ERR_CNT_W-1:0] data_errors,
    output logic [ERR_CNT_W-1:0] framing_errors,
    output logic                 error_seen,
    output logic [15:0]          first_err_packet,
    output logic [3:0]           first_err_word
);

    localparam logic [7:0] DEFAULT_PL = 8'd4;

    // Error counters stick at all-ones instead of wrapping back to a clean-looking value.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (&v) ? v : v + ERR_CNT_W'(1);
    endfunction

    logic                 tready_q, tready_d;
    logic [7:0]           latched_pl_q, latched_pl_d;
    logic [7:0]           exp_counter_q, exp_counter_d;
    logic [15:0]          exp_pkt_q, exp_pkt_d;
    logic [7:0]           cycle_index_q, cycle_index_d;
    logic [63:0]          packets_q, packets_d;
    logic [63:0]          cycles_q, cycles_d;
    logic [ERR_CNT_W-1:0] data_err_q, data_err_d;
    logic [ERR_CNT_W-1:0] frame_err_q, frame_err_d;
    logic                 error_seen_q, error_seen_d;
    logic [15:0]          first_err_packet_q, first_err_packet_d;
    logic [3:0]           first_err_word_q, first_err_word_d;

    logic [511:0] exp_data;
    logic [15:0]  word_bad;
    logic [3:0]   first_idx;
    logic         accept;
    logic         data_bad;
    logic         eop_exp;
    logic         frame_bad;

    // Expected beat, per-word mismatch flags and the lowest mismatching word.
    always_comb begin
        exp_data        = '0;
        exp_data[31:0]  = 32'hFFFF_FFFF;
        for (int i = 1; i < 16; i++) begin
            exp_data[i*32 +: 32] = {8'(i * 17), exp_counter_q, exp_pkt_q};
        end
        word_bad = '0;
        for (int i = 0; i < 16; i++) begin
            word_bad[i] = (AXIS_RX_TDATA[i*32 +: 32] != exp_data[i*32 +: 32]);
        end
        first_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (word_bad[i]) first_idx = 4'(i);
        end
    end

    assign accept    = AXIS_RX_TVALID & tready_q;
    assign data_bad  = (|word_bad) | (AXIS_RX_TKEEP != '1);
    assign eop_exp   = (cycle_index_q == latched_pl_q);
    // A short packet (early TLAST) and a missing TLAST at or past the expected end both
    // show up as TLAST disagreeing with the expected end-of-packet.
    assign frame_bad = AXIS_RX_TLAST ^ eop_exp;

    // Next-state: clear wins over any beat in the same cycle, which is dropped.
    always_comb begin
        tready_d           = ~rx_pause;
        latched_pl_d       = latched_pl_q;
        exp_counter_d      = exp_counter_q;
        exp_pkt_d          = exp_pkt_q;
        cycle_index_d      = cycle_index_q;
        packets_d          = packets_q;
        cycles_d           = cycles_q;
        data_err_d         = data_err_q;
        frame_err_d        = frame_err_q;
        error_seen_d       = error_seen_q;
        first_err_packet_d = first_err_packet_q;
        first_err_word_d   = first_err_word_q;

        if (clear) begin
            latched_pl_d       = (packet_length == 8'd0) ? DEFAULT_PL : packet_length;
            exp_counter_d      = '0;
            exp_pkt_d          = '0;
            cycle_index_d      = 8'd1;
            packets_d          = '0;
            cycles_d           = '0;
            data_err_d         = '0;
            frame_err_d        = '0;
            error_seen_d       = 1'b0;
            first_err_packet_d = '0;
            first_err_word_d   = '0;
        end else if (accept) begin
            cycles_d      = cycles_q + 64'd1;
            exp_counter_d = exp_counter_q + 8'd1;
            if (data_bad)  data_err_d  = sat_inc(data_err_q);
            if (frame_bad) frame_err_d = sat_inc(frame_err_q);
            if ((data_bad || frame_bad) && !error_seen_q) begin
                error_seen_d       = 1'b1;
                first_err_packet_d = exp_pkt_q;
                first_err_word_d   = first_idx;
            end
            if (AXIS_RX_TLAST) begin
                packets_d     = packets_q + 64'd1;
                exp_pkt_d     = exp_pkt_q + 16'd1;
                cycle_index_d = 8'd1;
            end else if (!eop_exp) begin
                cycle_index_d = cycle_index_q + 8'd1;
            end
        end
    end

    // State registers; reset leaves TREADY low and expects packet 0, counter 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tready_q           <= 1'b0;
            latched_pl_q       <= DEFAULT_PL;
            exp_counter_q      <= '0;
            exp_pkt_q          <= '0;
            cycle_index_q      <= 8'd1;
            packets_q          <= '0;
            cycles_q           <= '0;
            data_err_q         <= '0;
            frame_err_q        <= '0;
            error_seen_q       <= 1'b0;
            first_err_packet_q <= '0;
            first_err_word_q   <= '0;
        end else begin
            tready_q           <= tready_d;
            latched_pl_q       <= latched_pl_d;
            exp_counter_q      <= exp_counter_d;
            exp_pkt_q          <= exp_pkt_d;
            cycle_index_q      <= cycle_index_d;
            packets_q          <= packets_d;
            cycles_q           <= cycles_d;
            data_err_q         <= data_err_d;
            frame_err_q        <= frame_err_d;
            error_seen_q       <= error_seen_d;
            first_err_packet_q <= first_err_packet_d;
            first_err_word_q   <= first_err_word_d;
        end
    end

    assign AXIS_RX_TREADY   = tready_q;
    assign packets_received = packets_q;
    assign cycles_received  = cycles_q;
    assign data_errors      = data_err_q;
    assign framing_errors   = frame_err_q;
    assign error_seen       = error_seen_q;
    assign first_err_packet = first_err_packet_q;
    assign first_err_word   = first_err_word_q;

endmodule
